// File: rtl/rx_cmd_ctrl_pkg.sv
// Shared command-frame definitions: opcode codes, frame lengths, FSM states
// and the opcode prefix decoder used by rx and downstream command logic.
package rx_cmd_ctrl_pkg;

    localparam int CMD_DATA_W = 40;
    localparam int CMD_LEN_W  = 6;

    typedef enum logic [2:0] {
        CMD_NONE     = 3'd0,
        CMD_QUERYREP = 3'd1,
        CMD_ACK      = 3'd2,
        CMD_QUERY    = 3'd3,
        CMD_QUERYADJ = 3'd4,
        CMD_REQRN    = 3'd5
    } cmd_code_e;

    localparam logic [CMD_LEN_W-1:0] LEN_QUERYREP = 6'd4;
    localparam logic [CMD_LEN_W-1:0] LEN_ACK      = 6'd18;
    localparam logic [CMD_LEN_W-1:0] LEN_QUERY    = 6'd22;
    localparam logic [CMD_LEN_W-1:0] LEN_QUERYADJ = 6'd9;
    localparam logic [CMD_LEN_W-1:0] LEN_REQRN    = 6'd40;

    typedef enum logic [2:0] {
        ST_ARM     = 3'd0,
        ST_IDLE    = 3'd1,
        ST_OPCODE  = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_HOLD    = 3'd4
    } state_e;

    typedef struct packed {
        logic                 done;
        logic                 err;
        cmd_code_e            code;
        logic [CMD_LEN_W-1:0] len;
    } dec_t;

    // pfx holds the newest received bits, most recent in bit 0; n is the bit count.
    function automatic dec_t decode_prefix(input logic [7:0] pfx, input logic [CMD_LEN_W-1:0] n);
        dec_t d;
        d.done = 1'b0;
        d.err  = 1'b0;
        d.code = CMD_NONE;
        d.len  = '0;
        if (n == 6'd2 && !pfx[1]) begin
            d.done = 1'b1;
            d.code = pfx[0] ? CMD_ACK : CMD_QUERYREP;
            d.len  = pfx[0] ? LEN_ACK : LEN_QUERYREP;
        end else if (n == 6'd4 && pfx[3:2] == 2'b10) begin
            case (pfx[1:0])
                2'b00:   begin d.done = 1'b1; d.code = CMD_QUERY;    d.len = LEN_QUERY;    end
                2'b01:   begin d.done = 1'b1; d.code = CMD_QUERYADJ; d.len = LEN_QUERYADJ; end
                default: d.err = 1'b1;
            endcase
        end else if (n == 6'd8) begin
            if (pfx == 8'b1100_0001) begin
                d.done = 1'b1;
                d.code = CMD_REQRN;
                d.len  = LEN_REQRN;
            end else begin
                d.err = 1'b1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/rx_cmd_ctrl_if.sv
// Command frame handoff: frame fields and valid from rx_cmd_ctrl, ack from the consumer.
// cmd_valid holds with stable fields until cmd_ack is seen; cmd_err is a single-cycle pulse.
interface rx_cmd_ctrl_if;
    logic                                  cmd_valid;
    logic                                  cmd_ack;
    logic [2:0]                            cmd_code;
    logic [rx_cmd_ctrl_pkg::CMD_LEN_W-1:0]  cmd_len;
    logic [rx_cmd_ctrl_pkg::CMD_DATA_W-1:0] cmd_data;
    logic                                  cmd_err;

    modport master (output cmd_valid, cmd_code, cmd_len, cmd_data, cmd_err, input cmd_ack);
    modport slave  (input cmd_valid, cmd_code, cmd_len, cmd_data, cmd_err, output cmd_ack);
endinterface

// File: rtl/rx_bit_sync.sv
// Brings the rx bit strobe and data into clk: 2-flop sync on both, rising-edge detect on bitclk.
// bit_vld pulses one cycle, two clk edges after bitclk rises; no backpressure.
module rx_bit_sync (
    input  logic clk,
    input  logic reset,
    input  logic bitclk,
    input  logic bitin,
    output logic bit_vld,
    output logic bit_dat
);

    logic [1:0] clk_sync;
    logic [1:0] dat_sync;
    logic       clk_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync <= '0;
            dat_sync <= '0;
            clk_prev <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], bitclk};
            dat_sync <= {dat_sync[0], bitin};
            clk_prev <= clk_sync[1];
        end
    end

    assign bit_vld = clk_sync[1] & ~clk_prev;
    assign bit_dat = dat_sync[1];

endmodule

// File: rtl/rx_cmd_ctrl.sv
// Assembles rx bits into command frames, decodes the opcode and holds the frame until acked.
// cmd_valid rises 1 clk after the final synchronized bit; frame held (bits ignored) until cmd_ack.
module rx_cmd_ctrl
    import rx_cmd_ctrl_pkg::*;
#(
    parameter int TIMEOUT_MULT = 4,
    parameter int RST_HOLD     = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          bitin,
    input  logic          bitclk,
    input  logic          rx_overflow,
    input  logic [9:0]    trcal,
    output logic          rx_reset,
    rx_cmd_ctrl_if.master cmd
);

    localparam int                  ARM_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [ARM_W-1:0]    ARM_LAST = ARM_W'(RST_HOLD - 1);
    localparam logic [12:0]         MULT13   = 13'(TIMEOUT_MULT);

    state_e                  state_q, state_d;
    logic [ARM_W-1:0]        arm_cnt_q;
    logic [CMD_LEN_W-1:0]    bit_cnt_q, bit_cnt_nxt;
    logic [CMD_DATA_W-1:0]   data_q, shift_nxt;
    cmd_code_e               code_q;
    logic [CMD_LEN_W-1:0]    len_q;
    logic [12:0]             gap_q;
    logic [12:0]             limit;
    logic                    bit_vld, bit_dat;
    logic                    timeout, capture, err_evt;
    dec_t                    dec;

    rx_bit_sync u_sync (
        .clk     (clk),
        .reset   (reset),
        .bitclk  (bitclk),
        .bitin   (bitin),
        .bit_vld (bit_vld),
        .bit_dat (bit_dat)
    );

    assign shift_nxt   = {data_q[CMD_DATA_W-2:0], bit_dat};
    assign bit_cnt_nxt = bit_cnt_q + 6'd1;
    assign dec         = decode_prefix(shift_nxt[7:0], bit_cnt_nxt);
    assign limit       = MULT13 * {3'b000, trcal};
    // A zero limit means trcal is not yet measured, so the gap timer is off.
    assign timeout     = (limit != 13'd0) && ((gap_q + 13'd1) == limit);
    assign capture     = bit_vld && !rx_overflow &&
                         (state_q == ST_IDLE || state_q == ST_OPCODE || state_q == ST_PAYLOAD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_ARM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        err_evt = 1'b0;
        case (state_q)
            ST_ARM: begin
                if (arm_cnt_q == ARM_LAST) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (rx_overflow) begin
                    err_evt = 1'b1;
                    state_d = ST_ARM;
                end else if (bit_vld) begin
                    state_d = ST_OPCODE;
                end
            end
            ST_OPCODE: begin
                if (rx_overflow) begin
                    err_evt = 1'b1;
                    state_d = ST_ARM;
                end else if (bit_vld) begin
                    if (dec.err) begin
                        err_evt = 1'b1;
                        state_d = ST_ARM;
                    end else if (dec.done) begin
                        state_d = (bit_cnt_nxt == dec.len) ? ST_HOLD : ST_PAYLOAD;
                    end
                end else if (timeout) begin
                    err_evt = 1'b1;
                    state_d = ST_ARM;
                end
            end
            ST_PAYLOAD: begin
                if (rx_overflow) begin
                    err_evt = 1'b1;
                    state_d = ST_ARM;
                end else if (bit_vld) begin
                    if (bit_cnt_nxt == len_q) state_d = ST_HOLD;
                end else if (timeout) begin
                    err_evt = 1'b1;
                    state_d = ST_ARM;
                end
            end
            ST_HOLD: begin
                if (cmd.cmd_ack) state_d = ST_ARM;
            end
            default: state_d = ST_ARM;
        endcase
    end

    always_comb begin
        rx_reset      = (state_q == ST_ARM);
        cmd.cmd_valid = (state_q == ST_HOLD);
        cmd.cmd_code  = (state_q == ST_HOLD) ? code_q : CMD_NONE;
        cmd.cmd_len   = len_q;
        cmd.cmd_data  = data_q;
        cmd.cmd_err   = err_evt;
    end

    // Frame datapath; everything is cleared while re-arming so IDLE starts from zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            arm_cnt_q <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            code_q    <= CMD_NONE;
            len_q     <= '0;
            gap_q     <= '0;
        end else begin
            arm_cnt_q <= (state_q == ST_ARM) ? arm_cnt_q + 1'b1 : '0;
            if (state_q == ST_ARM) begin
                bit_cnt_q <= '0;
                data_q    <= '0;
                code_q    <= CMD_NONE;
                len_q     <= '0;
                gap_q     <= '0;
            end else if (capture) begin
                data_q    <= shift_nxt;
                bit_cnt_q <= bit_cnt_nxt;
                gap_q     <= '0;
                if (state_q == ST_OPCODE && dec.done) begin
                    code_q <= dec.code;
                    len_q  <= dec.len;
                end
            end else if (gap_q != 13'h1fff) begin
                gap_q <= gap_q + 13'd1;
            end
        end
    end

endmodule

// File: tb/tb_rx_cmd_ctrl.sv
// Directed and randomized frames against a table-driven command model.
module tb_rx_cmd_ctrl;

    localparam int RST_HOLD = 8;

    typedef bit bitq_t[$];
    typedef struct {
        bit          err;
        logic [2:0]  code;
        logic [5:0]  len;
        logic [39:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       bitin = 1'b0;
    logic       bitclk = 1'b0;
    logic       rx_overflow = 1'b0;
    logic [9:0] trcal = 10'd0;
    logic       rx_reset;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;

    rx_cmd_ctrl_if cmd_if ();

    rx_cmd_ctrl #(.TIMEOUT_MULT(4), .RST_HOLD(RST_HOLD)) dut (
        .clk         (clk),
        .reset       (reset),
        .bitin       (bitin),
        .bitclk      (bitclk),
        .rx_overflow (rx_overflow),
        .trcal       (trcal),
        .rx_reset    (rx_reset),
        .cmd         (cmd_if)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        #1;
        if (cmd_if.cmd_err === 1'b1) err_seen++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: each command is a fixed prefix with a fixed total length.
    function automatic exp_t model(input bitq_t q);
        exp_t m;
        int tp_val[5];
        int tp_len[5];
        int tp_code[5];
        int tp_flen[5];
        int v;
        tp_val  = '{0, 1, 8, 9, 193};
        tp_len  = '{2, 2, 4, 4, 8};
        tp_code = '{1, 2, 3, 4, 5};
        tp_flen = '{4, 18, 22, 9, 40};
        m.err = 1'b1; m.code = 3'd0; m.len = 6'd0; m.data = 40'd0;
        for (int i = 0; i < 5; i++) begin
            if (q.size() >= tp_len[i]) begin
                v = 0;
                for (int k = 0; k < tp_len[i]; k++) v = v * 2 + int'(q[k]);
                if (v == tp_val[i]) begin
                    m.err  = 1'b0;
                    m.code = 3'(tp_code[i]);
                    m.len  = 6'(tp_flen[i]);
                end
            end
        end
        foreach (q[k]) m.data = {m.data[38:0], q[k]};
        return m;
    endfunction

    // kind 0..4: valid commands with random payload; 5: bad 10xx; other: bad 11xxxxxx.
    function automatic bitq_t gen_frame(input int kind);
        bitq_t q;
        int pv, pl, flen;
        case (kind)
            0:       begin pv = 0;   pl = 2; flen = 4;  end
            1:       begin pv = 1;   pl = 2; flen = 18; end
            2:       begin pv = 8;   pl = 4; flen = 22; end
            3:       begin pv = 9;   pl = 4; flen = 9;  end
            4:       begin pv = 193; pl = 8; flen = 40; end
            5:       begin pv = 10 + int'($urandom_range(0, 1)); pl = 4; flen = 4; end
            default: begin pv = 192 | int'($urandom_range(2, 63)); pl = 8; flen = 8; end
        endcase
        for (int i = pl - 1; i >= 0; i--) q.push_back(pv[i]);
        while (q.size() < flen) q.push_back(bit'($urandom_range(0, 1)));
        return q;
    endfunction

    task automatic send_bit(input bit b, input int hi, input int lo);
        bitin = b;
        @(negedge clk);
        bitclk = 1'b1;
        repeat (hi) @(negedge clk);
        bitclk = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic raise_last(input bit b);
        bitin = b;
        @(negedge clk);
        bitclk = 1'b1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (rx_reset === 1'b1 && n < 100) begin @(negedge clk); n++; end
        chk("idle_reached", rx_reset, 0);
    endtask

    task automatic arm_len(input string tag);
        int n = 0;
        while (rx_reset === 1'b1 && n < 100) begin n++; @(negedge clk); end
        chk(tag, n, RST_HOLD);
    endtask

    task automatic do_ack();
        cmd_if.cmd_ack = 1'b1;
        @(negedge clk);
        cmd_if.cmd_ack = 1'b0;
    endtask

    task automatic run_frame(input bitq_t q);
        exp_t e;
        int e0, n;
        e = model(q);
        wait_idle();
        e0 = err_seen;
        foreach (q[i]) send_bit(q[i], $urandom_range(2, 6), $urandom_range(2, 6));
        n = 0;
        while (cmd_if.cmd_valid !== 1'b1 && n < 6) begin @(negedge clk); n++; end
        if (e.err) begin
            chk("bad_opcode_err", err_seen - e0, 1);
            chk("bad_opcode_novalid", cmd_if.cmd_valid, 0);
        end else begin
            chk("frame_valid", cmd_if.cmd_valid, 1);
            chk("frame_code", cmd_if.cmd_code, e.code);
            chk("frame_len", cmd_if.cmd_len, e.len);
            chk("frame_data", cmd_if.cmd_data, e.data);
            chk("frame_noerr", err_seen - e0, 0);
            do_ack();
            chk("code_zero_after_ack", cmd_if.cmd_code, 0);
        end
    endtask

    initial begin
        bitq_t q;
        logic [21:0] qbits;
        int e0;

        cmd_if.cmd_ack = 1'b0;
        #12;
        chk("rst_rx_reset", rx_reset, 1);
        chk("rst_valid", cmd_if.cmd_valid, 0);
        chk("rst_err", cmd_if.cmd_err, 0);
        chk("rst_code", cmd_if.cmd_code, 0);
        chk("rst_len", cmd_if.cmd_len, 0);
        chk("rst_data", cmd_if.cmd_data, 0);
        @(negedge clk);
        reset = 1'b1;
        arm_len("arm_after_reset");

        // QueryRep 0011 with latency check on the final bit
        trcal = 10'd100;
        e0 = err_seen;
        send_bit(1'b0, 3, 3);
        send_bit(1'b0, 3, 3);
        send_bit(1'b1, 3, 3);
        raise_last(1'b1);
        repeat (2) @(negedge clk);
        chk("qrep_valid_strobe_cycle", cmd_if.cmd_valid, 0);
        chk("qrep_code_zero_while_invalid", cmd_if.cmd_code, 0);
        @(negedge clk);
        bitclk = 1'b0;
        chk("qrep_valid_next_cycle", cmd_if.cmd_valid, 1);
        chk("qrep_code", cmd_if.cmd_code, 1);
        chk("qrep_len", cmd_if.cmd_len, 4);
        chk("qrep_data", cmd_if.cmd_data, 40'h3);
        chk("qrep_noerr", err_seen - e0, 0);
        do_ack();
        arm_len("arm_after_qrep_ack");

        // Query held without ack while extra bit edges arrive
        qbits = 22'b1000_0101010101010101_01;
        for (int i = 21; i >= 0; i--) send_bit(qbits[i], $urandom_range(2, 5), $urandom_range(2, 5));
        chk("query_valid", cmd_if.cmd_valid, 1);
        for (int i = 0; i < 5; i++) send_bit(bit'($urandom_range(0, 1)), 4, 4);
        repeat (5) @(negedge clk);
        chk("query_hold_valid", cmd_if.cmd_valid, 1);
        chk("query_hold_code", cmd_if.cmd_code, 3);
        chk("query_hold_len", cmd_if.cmd_len, 22);
        chk("query_hold_data", cmd_if.cmd_data, 40'h215555);
        do_ack();
        arm_len("arm_after_query_ack");

        // Unsupported opcode 1010: error on the fourth bit
        e0 = err_seen;
        send_bit(1'b1, 3, 3);
        send_bit(1'b0, 3, 3);
        send_bit(1'b1, 3, 3);
        raise_last(1'b0);
        repeat (2) @(negedge clk);
        chk("bad1010_err_on_bit4", cmd_if.cmd_err, 1);
        @(negedge clk);
        bitclk = 1'b0;
        chk("bad1010_err_one_cycle", cmd_if.cmd_err, 0);
        chk("bad1010_novalid", cmd_if.cmd_valid, 0);
        chk("bad1010_one_pulse", err_seen - e0, 1);
        arm_len("arm_after_bad_opcode");

        // ACK truncated after 10 bits: timeout exactly 4*trcal cycles after last bit
        trcal = 10'd50;
        q = gen_frame(1);
        for (int i = 0; i < 9; i++) send_bit(q[i], $urandom_range(2, 6), $urandom_range(2, 6));
        raise_last(q[9]);
        repeat (2) @(negedge clk);
        repeat (199) @(negedge clk);
        chk("timeout_not_early", cmd_if.cmd_err, 0);
        @(negedge clk);
        chk("timeout_at_200", cmd_if.cmd_err, 1);
        @(negedge clk);
        bitclk = 1'b0;
        chk("timeout_one_cycle", cmd_if.cmd_err, 0);
        arm_len("arm_after_timeout");

        // ReqRN with overflow during bit 12, then a clean QueryAdjust
        trcal = 10'd100;
        q = gen_frame(4);
        e0 = err_seen;
        for (int i = 0; i < 11; i++) send_bit(q[i], $urandom_range(2, 6), $urandom_range(2, 6));
        raise_last(q[11]);
        rx_overflow = 1'b1;
        repeat (2) @(negedge clk);
        rx_overflow = 1'b0;
        bitclk = 1'b0;
        chk("ovf_in_arm", rx_reset, 1);
        chk("ovf_one_err", err_seen - e0, 1);
        chk("ovf_novalid", cmd_if.cmd_valid, 0);
        run_frame(gen_frame(3));

        // Overflow coinciding with the final bit of a QueryRep
        wait_idle();
        e0 = err_seen;
        send_bit(1'b0, 3, 3);
        send_bit(1'b0, 3, 3);
        send_bit(1'b1, 3, 3);
        raise_last(1'b0);
        repeat (2) @(negedge clk);
        rx_overflow = 1'b1;
        @(negedge clk);
        rx_overflow = 1'b0;
        bitclk = 1'b0;
        @(negedge clk);
        chk("ovf_final_err", err_seen - e0, 1);
        chk("ovf_final_novalid", cmd_if.cmd_valid, 0);

        // Timeout disabled with trcal=0
        wait_idle();
        trcal = 10'd0;
        e0 = err_seen;
        send_bit(1'b0, 3, 3);
        send_bit(1'b0, 3, 3);
        repeat (300) @(negedge clk);
        chk("trcal0_no_err", err_seen - e0, 0);
        chk("trcal0_still_rx", rx_reset, 0);
        send_bit(1'b1, 3, 3);
        send_bit(1'b0, 3, 3);
        chk("trcal0_valid", cmd_if.cmd_valid, 1);
        chk("trcal0_data", cmd_if.cmd_data, 40'h2);
        do_ack();

        // Reset asserted at bit 5 of a Query
        trcal = 10'd100;
        wait_idle();
        q = gen_frame(2);
        e0 = err_seen;
        for (int i = 0; i < 4; i++) send_bit(q[i], 3, 3);
        raise_last(q[4]);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_rx_reset", rx_reset, 1);
        chk("midrst_valid", cmd_if.cmd_valid, 0);
        chk("midrst_err", cmd_if.cmd_err, 0);
        chk("midrst_code", cmd_if.cmd_code, 0);
        chk("midrst_len", cmd_if.cmd_len, 0);
        chk("midrst_data", cmd_if.cmd_data, 0);
        repeat (3) @(negedge clk);
        bitclk = 1'b0;
        reset = 1'b1;
        chk("midrst_no_err_pulse", err_seen - e0, 0);
        arm_len("arm_after_midrst");
        run_frame(gen_frame(2));

        // Randomized frames of every kind with random trcal
        for (int it = 0; it < 10; it++) begin
            wait_idle();
            trcal = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(20, 400));
            run_frame(gen_frame($urandom_range(0, 6)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_cmd_ctrl.md
RX_CMD_CTRL -- requirements
Module: rx_cmd_ctrl

Interface
REQ-001 Parameter TIMEOUT_MULT, default 4: bit-gap timeout is TIMEOUT_MULT*trcal clk cycles.
REQ-002 Parameter RST_HOLD, default 8: number of clk cycles rx_reset is held on each re-arm.
REQ-003 clk  in  1  system clock; sole clock of the block.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 bitin  in  1  demodulated bit from rx (rx bitout).
REQ-006 bitclk  in  1  bit strobe from rx; asynchronous to clk; bitin is valid at its rising edge.
REQ-007 rx_overflow  in  1  rx overflow flag (rx rx_overflow_reset), level.
REQ-008 trcal  in  10  TRcal measured by rx, in clk cycles.
REQ-009 rx_reset  out  1  active-high hold-in-reset to rx.
REQ-010 cmd_valid  out  1  command frame available.
REQ-011 cmd_ack  in  1  consumer accepts frame.
REQ-012 cmd_code  out  3  1=QueryRep, 2=ACK, 3=Query, 4=QueryAdjust, 5=ReqRN; 0 otherwise.
REQ-013 cmd_len  out  6  total frame bits including opcode.
REQ-014 cmd_data  out  40  frame bits, right-aligned, first-received bit most significant.
REQ-015 cmd_err  out  1  one-cycle pulse: unsupported opcode, timeout or overflow.

Function
REQ-016 bitclk and bitin: each passes through a 2-flop synchronizer; a bit is sampled on the cycle the synchronized bitclk rises.
REQ-017 States: ARM, IDLE, OPCODE, PAYLOAD, HOLD.
REQ-018 ARM: rx_reset=1 for RST_HOLD cycles, then go to IDLE.
REQ-019 IDLE: first sampled bit goes to OPCODE with bit count 1.
REQ-020 OPCODE decode uses the first bits received:
  - 00 -> QueryRep, len 4
  - 01 -> ACK, len 18
  - 1000 -> Query, len 22
  - 1001 -> QueryAdjust, len 9
  - 11000001 -> ReqRN, len 40
  - any other 4-bit (10xx) or 8-bit (11xxxxxx) prefix -> error
REQ-021 Once the opcode is decoded, the FSM enters PAYLOAD; if that bit completes len, it goes directly to HOLD.
REQ-022 PAYLOAD: shift each sampled bit into cmd_data; when bit count equals len, go to HOLD.
REQ-023 HOLD: cmd_valid=1 and cmd_code/cmd_len/cmd_data stay stable; bitclk edges are ignored.
REQ-024 In HOLD, the cycle with cmd_valid=1 and cmd_ack=1 is the transfer cycle; the FSM goes to ARM on the next cycle.
REQ-025 cmd_valid asserts the cycle after the final bit is sampled (latency of 1 clk after the synchronized edge).
REQ-026 Timeout: a gap counter clears on each sampled bit.
  - In OPCODE/PAYLOAD, if the counter reaches TIMEOUT_MULT*trcal: pulse cmd_err, go to ARM.
  - If trcal=0, the timeout is disabled.
  - The product is computed at 13 bits, without truncation.
REQ-027 rx_overflow=1 in IDLE, OPCODE or PAYLOAD: pulse cmd_err, go to ARM. rx_overflow is ignored in ARM and HOLD.
REQ-028 Unsupported opcode: pulse cmd_err on the decode cycle, go to ARM.
REQ-029 Simultaneous bit edge and timeout: the bit wins; the counter clears.
REQ-030 Simultaneous overflow and final bit: overflow wins; no cmd_valid.
REQ-031 cmd_code holds 0 whenever cmd_valid=0.

Reset
REQ-032 reset=0 asynchronously forces state ARM and zeroes all counters and registers.
REQ-033 Output values during reset: rx_reset=1, cmd_valid=0, cmd_err=0, cmd_code=0, cmd_len=0, cmd_data=0.
REQ-034 After release, the block runs a full RST_HOLD arm sequence.
REQ-035 reset asserted mid-frame discards the frame without a cmd_err pulse.

Structure
REQ-036 cmd_code encodings, the per-opcode lengths and the state encodings belong in a shared package used by rx and the downstream command logic.
REQ-037 The bitclk/bitin 2-flop synchronizer with edge detect is one sub-module, rx_bit_sync.

Verification
REQ-038 QueryRep: bits 0,0,1,1 with trcal=100 -> cmd_valid; cmd_code=1, cmd_len=4, cmd_data=40'h3.
REQ-039 Query: 22 bits 1000_0101010101010101_01 -> cmd_code=3, cmd_len=22, cmd_data=40'h215555. Holding cmd_ack=0 for 50 cycles while sending 5 extra edges leaves the outputs unchanged; ack -> rx_reset high for 8 cycles.
REQ-040 Opcode 1010 -> cmd_err pulse on the 4th bit, no cmd_valid, rx_reset high for 8 cycles.
REQ-041 ACK with trcal=50: stop after 10 bits -> cmd_err exactly 200 cycles after the last sampled bit.
REQ-042 rx_overflow pulsed during the 12th bit of ReqRN -> cmd_err, ARM; a following valid QueryAdjust (9 bits) is received correctly.
REQ-043 reset=0 at bit 5 of Query -> outputs at reset values immediately, no cmd_err; a frame after release decodes correctly.
